speed_tick_gen: RTL and testbench
=================================

SPEED_TICK_GEN -- requirements
Module: speed_tick_gen

Interface
REQ-001 Parameter SEL_W, default 2: width of speed-select input; number of levels N = 2^SEL_W.
REQ-002 Parameter CNT_W, default 26: width of period counter.
REQ-003 Parameter BASE_PERIOD, default 50_000_000: tick period in clocks at level 0; SHALL be >= 2^(N-1) and < 2^CNT_W.
REQ-004 Parameter RAMP_EN, default 0: 0 = direct mode, 1 = ramp mode.
REQ-005 CLOCK_50  input  1  system clock; all state changes on its rising edge.
REQ-006 resetn  input  1  asynchronous, active-low reset.
REQ-007 SW  input  SEL_W  requested speed level, asynchronous to CLOCK_50.
REQ-008 pause  input  1  synchronous; 1 freezes counter and suppresses ticks.
REQ-009 speed  output  SEL_W  currently applied speed level, registered.
REQ-010 tick  output  1  one-cycle block-shift enable pulse, registered.
REQ-011 count  output  CNT_W  current period counter value, registered.

Function
REQ-012 SW SHALL pass through a 2-flop synchronizer; only the synchronized value (req) is used internally.
REQ-013 Period for level L SHALL be P(L) = BASE_PERIOD >> L (integer shift, truncated); P(L) >= 1 for all L is guaranteed by REQ-003.
REQ-014 Counter counts 0 .. P(speed)-1; when count == P(speed)-1 and pause == 0, next cycle: count = 0 and tick = 1 for exactly one cycle.
REQ-015 tick SHALL be 0 in every cycle not produced by REQ-014 or REQ-017.
REQ-016 pause == 1: count holds, tick = 0, speed holds; on pause deassert counting resumes from held value.
REQ-017 Direct mode: speed SHALL load req one cycle after req changes; if count >= P(new speed)-1 at that load, next cycle count = 0 and tick = 1 (no overrun past new period).
REQ-018 Ramp mode: speed SHALL move one level toward req per tick (increment if req > speed, decrement if req < speed), updated in the same cycle tick is asserted; period in force for the next interval is P(updated speed).
REQ-019 Ramp mode: speed == req means no change; req changing mid-interval takes effect only at the next tick.
REQ-020 Ramp mode SHALL NOT apply REQ-017 early-tick rule.
REQ-021 Pause takes priority over speed updates in both modes; req changes during pause are applied (direct) or stepped (ramp) only after pause deasserts.
REQ-022 count arithmetic SHALL be unsigned CNT_W-bit; comparison uses P(speed)-1 computed at CNT_W bits, no wrap permitted.
REQ-023 Speed levels SHALL saturate at 0 and N-1; no wrap-around in ramp mode.

Reset
REQ-024 While resetn == 0: speed = 0, tick = 0, count = 0, synchronizer flops = 0, asynchronously.
REQ-025 First count increment SHALL occur on the first rising edge with resetn == 1; reset asserted mid-interval discards the partial interval.
REQ-026 After reset, first tick (level 0, no pause) SHALL occur BASE_PERIOD cycles after reset release.

Verification (use BASE_PERIOD = 16, CNT_W = 8, SEL_W = 2 bench override)
REQ-027 Direct, SW = 0 held from reset -> tick every 16 cycles, count sequence 0..15, speed = 0.
REQ-028 Direct, SW = 3 steady -> speed = 3 after 3 cycles of synchronizer+load, tick every 2 cycles.
REQ-029 Direct, at count = 10 on level 0 switch SW to 2 (P = 4) -> speed = 2, then count = 0 and tick = 1 in next cycle, thereafter tick every 4 cycles.
REQ-030 Ramp, speed 0, SW to 3 -> speed steps 0->1->2->3 at consecutive ticks, intervals 16, 8, 4, then 2 cycles.
REQ-031 pause = 1 for 20 cycles at count = 7 -> count stays 7, no tick, SW change ignored; after release tick 9 cycles later (level unchanged).
REQ-032 resetn pulsed low at count = 12, level 2 -> speed = 0, count = 0, tick = 0 immediately; first tick 16 cycles after release with SW = 0.

Source files
------------

// File: rtl/speed_tick_gen.sv
// Periodic tick generator with selectable speed levels: period halves per level.
// Direct mode jumps straight to the requested level; ramp mode steps one level per tick.
module speed_tick_gen #(
    parameter int SEL_W       = 2,
    parameter int CNT_W       = 26,
    parameter int BASE_PERIOD = 50_000_000,
    parameter int RAMP_EN     = 0
) (
    input  logic             CLOCK_50,
    input  logic             resetn,
    input  logic [SEL_W-1:0] SW,
    input  logic             pause,
    output logic [SEL_W-1:0] speed,
    output logic             tick,
    output logic [CNT_W-1:0] count
);

    localparam int N = 2 ** SEL_W;

    logic [SEL_W-1:0] sync_meta;
    logic [SEL_W-1:0] req;
    logic [CNT_W-1:0] last_count [N];
    logic [SEL_W-1:0] speed_next;
    logic             wrap;

    // Terminal count per level, P(L)-1, fixed at elaboration time.
    for (genvar gi = 0; gi < N; gi++) begin : g_period
        localparam logic [CNT_W-1:0] PERIOD = CNT_W'(BASE_PERIOD >> gi);
        assign last_count[gi] = PERIOD - CNT_W'(1);
    end

    always_comb begin
        wrap       = 1'b0;
        speed_next = speed;
        if (RAMP_EN == 0) begin
            // Judging against the requested level cuts a long interval short when speeding up.
            wrap       = (count >= last_count[req]);
            speed_next = req;
        end else begin
            wrap = (count == last_count[speed]);
            if (wrap) begin
                if (req > speed)
                    speed_next = speed + 1'b1;
                else if (req < speed)
                    speed_next = speed - 1'b1;
            end
        end
    end

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            sync_meta <= '0;
            req       <= '0;
            speed     <= '0;
            tick      <= 1'b0;
            count     <= '0;
        end else begin
            sync_meta <= SW;
            req       <= sync_meta;
            if (pause) begin
                tick <= 1'b0;
            end else begin
                speed <= speed_next;
                tick  <= wrap;
                count <= wrap ? '0 : count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_speed_tick_gen.sv
// Directed bench: one direct-mode and one ramp-mode instance at BASE_PERIOD = 16.
module tb_speed_tick_gen;

    logic       clk;
    logic       resetn;
    logic [1:0] sw_d, sw_r;
    logic       pause_d, pause_r;
    logic [1:0] speed_d, speed_r;
    logic       tick_d, tick_r;
    logic [7:0] count_d, count_r;

    int n_cmp = 0;
    int n_err = 0;

    speed_tick_gen #(.SEL_W(2), .CNT_W(8), .BASE_PERIOD(16), .RAMP_EN(0)) dut_d (
        .CLOCK_50(clk), .resetn(resetn), .SW(sw_d), .pause(pause_d),
        .speed(speed_d), .tick(tick_d), .count(count_d)
    );

    speed_tick_gen #(.SEL_W(2), .CNT_W(8), .BASE_PERIOD(16), .RAMP_EN(1)) dut_r (
        .CLOCK_50(clk), .resetn(resetn), .SW(sw_r), .pause(pause_r),
        .speed(speed_r), .tick(tick_r), .count(count_r)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic wait_tick(input bit ramp, output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (!(ramp ? tick_r : tick_d) && n < 200);
        if (!(ramp ? tick_r : tick_d)) begin
            n_cmp++;
            n_err++;
            $error("FAIL wait_tick: observed no tick expected tick within 200 cycles");
        end
    endtask

    initial begin
        int n;
        bit saw;
        resetn  = 1'b0;
        sw_d    = 2'd0;
        sw_r    = 2'd0;
        pause_d = 1'b0;
        pause_r = 1'b0;
        step();
        step();
        chk("rst_count", count_d, 0);
        chk("rst_tick", tick_d, 0);
        chk("rst_speed", speed_d, 0);

        // Level 0 from reset: count 1..15 then wrap with tick on edge 16.
        resetn = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            step();
            chk($sformatf("l0_count_%0d", k), count_d, k % 16);
            chk($sformatf("l0_tick_%0d", k), tick_d, (k == 16) ? 1 : 0);
        end
        wait_tick(1'b0, n);
        chk("l0_interval", n, 16);
        chk("l0_speed", speed_d, 0);
        $display("txn level0: interval %0d speed %0d", n, speed_d);

        // Switch to level 2 at count 10: load overshoots P(2) so it wraps immediately.
        repeat (10) step();
        chk("sw2_count10", count_d, 10);
        sw_d = 2'd2;
        step();
        step();
        chk("sw2_pre_count", count_d, 12);
        chk("sw2_pre_speed", speed_d, 0);
        step();
        chk("sw2_speed", speed_d, 2);
        chk("sw2_count", count_d, 0);
        chk("sw2_tick", tick_d, 1);
        wait_tick(1'b0, n);
        chk("sw2_interval_a", n, 4);
        wait_tick(1'b0, n);
        chk("sw2_interval_b", n, 4);
        $display("txn direct sw=2: interval %0d speed %0d", n, speed_d);

        // Level 3: speed applied three edges after SW changes.
        sw_d = 2'd3;
        step();
        step();
        chk("sw3_pre_speed", speed_d, 2);
        step();
        chk("sw3_speed", speed_d, 3);
        chk("sw3_tick", tick_d, 1);
        wait_tick(1'b0, n);
        chk("sw3_interval_a", n, 2);
        wait_tick(1'b0, n);
        chk("sw3_interval_b", n, 2);
        $display("txn direct sw=3: interval %0d speed %0d", n, speed_d);

        // Pause at count 7 on level 0 for 20 cycles with a transient SW change.
        sw_d = 2'd0;
        repeat (4) step();
        chk("p_speed0", speed_d, 0);
        wait_tick(1'b0, n);
        repeat (7) step();
        chk("p_count7", count_d, 7);
        pause_d = 1'b1;
        sw_d    = 2'd3;
        saw     = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (tick_d) saw = 1'b1;
            if (i == 9) sw_d = 2'd0;
        end
        chk("p_hold_count", count_d, 7);
        chk("p_hold_speed", speed_d, 0);
        chk("p_no_tick", saw, 0);
        pause_d = 1'b0;
        wait_tick(1'b0, n);
        chk("p_resume_interval", n, 9);
        chk("p_resume_speed", speed_d, 0);
        $display("txn pause: resume interval %0d speed %0d", n, speed_d);

        // Ramp up 0 -> 3: one level per tick, intervals 16, 8, 4, 2.
        wait_tick(1'b1, n);
        sw_r = 2'd3;
        wait_tick(1'b1, n);
        chk("ru_int1", n, 16);
        chk("ru_speed1", speed_r, 1);
        wait_tick(1'b1, n);
        chk("ru_int2", n, 8);
        chk("ru_speed2", speed_r, 2);
        wait_tick(1'b1, n);
        chk("ru_int3", n, 4);
        chk("ru_speed3", speed_r, 3);
        wait_tick(1'b1, n);
        chk("ru_int4", n, 2);
        chk("ru_sat3", speed_r, 3);
        $display("txn ramp up: last interval %0d speed %0d", n, speed_r);

        // Ramp down: request arrives after the synchronizer, so the first tick keeps level 3.
        sw_r = 2'd0;
        wait_tick(1'b1, n);
        chk("rd_int1", n, 2);
        chk("rd_speed3", speed_r, 3);
        wait_tick(1'b1, n);
        chk("rd_int2", n, 2);
        chk("rd_speed2", speed_r, 2);
        wait_tick(1'b1, n);
        chk("rd_int3", n, 4);
        chk("rd_speed1", speed_r, 1);
        wait_tick(1'b1, n);
        chk("rd_int4", n, 8);
        chk("rd_speed0", speed_r, 0);
        $display("txn ramp down: last interval %0d speed %0d", n, speed_r);

        // Ramp mid-interval request: no early tick, current interval completes.
        repeat (10) step();
        chk("rm_count10", count_r, 10);
        sw_r = 2'd3;
        wait_tick(1'b1, n);
        chk("rm_interval", n, 6);
        chk("rm_speed", speed_r, 1);
        $display("txn ramp mid-interval: interval %0d speed %0d", n, speed_r);

        // Asynchronous reset mid-interval at level 2.
        sw_d = 2'd2;
        repeat (5) step();
        chk("r2_speed_before", speed_d, 2);
        resetn = 1'b0;
        sw_d   = 2'd0;
        sw_r   = 2'd0;
        #1;
        chk("ar_speed", speed_d, 0);
        chk("ar_count", count_d, 0);
        chk("ar_tick", tick_d, 0);
        chk("ar_ramp_speed", speed_r, 0);
        chk("ar_ramp_count", count_r, 0);
        step();
        step();
        resetn = 1'b1;
        wait_tick(1'b0, n);
        chk("ar_first_tick", n, 16);
        chk("ar_ramp_tick", tick_r, 1);
        chk("ar_speed_after", speed_d, 0);
        $display("txn reset release: first tick after %0d cycles", n);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
